// File: rtl/obco_ser_pkg.sv
// Shared types and constants for the OBCO framed serial transmitter.
package obco_ser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Bits on the line for one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/obco_bit_timer.sv
// Bit-period timer: latches the divider on load and ticks on the last cycle of each bit.
module obco_bit_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == div_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div;
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/obco_ser_tx.sv
// Framed parallel-to-serial transmitter feeding OBCO.I from a flop-driven SO line.
module obco_ser_tx
  import obco_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [DIV_W-1:0]  DIV,
  input  logic [DATA_W-1:0] TDATA,
  input  logic              TVALID,
  output logic              TREADY,
  output logic              SO,
  output logic              BUSY
);

  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("obco_ser_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("obco_ser_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("obco_ser_tx: DATA_W must be 5..9");
  end

  localparam int unsigned CntW = $clog2(DATA_W);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              stop_cnt_q;
  logic              par_q;
  logic              so_q;
  logic              accept;
  logic              tick;

  assign accept = TVALID && (state_q == StIdle);
  // Gated by RSTN so the block never advertises readiness while held in reset.
  assign TREADY = (state_q == StIdle) && RSTN;
  assign BUSY   = (state_q != StIdle);
  assign SO     = so_q;

  obco_bit_timer #(
    .DIV_W(DIV_W)
  ) u_bit_timer (
    .CLK (CLK),
    .RSTN(RSTN),
    .load(accept),
    .div (DIV),
    .tick(tick)
  );

  // so_q is loaded with the level of the state being entered, keeping SO purely registered.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      so_q       <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (TVALID) begin
            shreg_q    <= TDATA;
            par_q      <= (PARITY == PAR_ODD) ? ~(^TDATA) : ^TDATA;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            state_q    <= StStart;
            so_q       <= 1'b0;
          end
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            so_q    <= shreg_q[0];
          end
        end
        StData: begin
          if (tick) begin
            if (bit_cnt_q == CntW'(DATA_W - 1)) begin
              if (PARITY != PAR_NONE) begin
                state_q <= StPar;
                so_q    <= par_q;
              end else begin
                state_q <= StStop;
                so_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              shreg_q   <= shreg_q >> 1;
              so_q      <= shreg_q[1];
            end
          end
        end
        StPar: begin
          if (tick) begin
            state_q <= StStop;
            so_q    <= 1'b1;
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
            so_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          so_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obco_ser_tx.sv
// Directed bench for obco_ser_tx across parity and stop-bit configurations.
module tb_obco_ser_tx;

  logic        clk;
  logic        rstn;
  logic [15:0] div;
  logic [7:0]  tdata;
  logic        tvalid [4];
  logic        tready [4];
  logic        so     [4];
  logic        busy   [4];

  int checks;
  int errors;

  // 0: no parity, 1 stop; 1: even parity; 2: odd parity; 3: no parity, 2 stops
  obco_ser_tx #(.DATA_W(8), .DIV_W(16), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .CLK(clk), .RSTN(rstn), .DIV(div), .TDATA(tdata), .TVALID(tvalid[0]),
    .TREADY(tready[0]), .SO(so[0]), .BUSY(busy[0])
  );
  obco_ser_tx #(.DATA_W(8), .DIV_W(16), .PARITY(1), .STOP_BITS(1)) u_pe (
    .CLK(clk), .RSTN(rstn), .DIV(div), .TDATA(tdata), .TVALID(tvalid[1]),
    .TREADY(tready[1]), .SO(so[1]), .BUSY(busy[1])
  );
  obco_ser_tx #(.DATA_W(8), .DIV_W(16), .PARITY(2), .STOP_BITS(1)) u_po (
    .CLK(clk), .RSTN(rstn), .DIV(div), .TDATA(tdata), .TVALID(tvalid[2]),
    .TREADY(tready[2]), .SO(so[2]), .BUSY(busy[2])
  );
  obco_ser_tx #(.DATA_W(8), .DIV_W(16), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .CLK(clk), .RSTN(rstn), .DIV(div), .TDATA(tdata), .TVALID(tvalid[3]),
    .TREADY(tready[3]), .SO(so[3]), .BUSY(busy[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int sel);
    chk({tag, "_so"}, so[sel], 1'b1);
    chk({tag, "_busy"}, busy[sel], 1'b0);
    chk({tag, "_tready"}, tready[sel], 1'b1);
  endtask

  task automatic send(input string tag, input int sel, input logic [7:0] d,
                      input logic [15:0] dv);
    tdata       = d;
    div         = dv;
    tvalid[sel] = 1'b1;
    chk({tag, "_ready_pre"}, tready[sel], 1'b1);
    step();
    tvalid[sel] = 1'b0;
  endtask

  // seq[k] is the expected SO level of bit k; each bit lasts 'per' cycles.
  task automatic check_frame(input string tag, input int sel, input logic [0:31] seq,
                             input int nbits, input int per);
    for (int i = 0; i < nbits * per; i++) begin
      chk($sformatf("%s_so[%0d]", tag, i), so[sel], seq[i / per]);
      chk($sformatf("%s_busy[%0d]", tag, i), busy[sel], 1'b1);
      chk($sformatf("%s_tready[%0d]", tag, i), tready[sel], 1'b0);
      step();
    end
    chk_idle({tag, "_end"}, sel);
  endtask

  logic [0:31] seq;

  initial begin
    checks = 0;
    errors = 0;
    div    = '0;
    tdata  = '0;
    for (int k = 0; k < 4; k++) tvalid[k] = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;

    // Reset values
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_so%0d", k), so[k], 1'b1);
      chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_tready%0d", k), tready[k], 1'b0);
    end
    rstn = 1'b1;
    #1;
    chk("rel_tready", tready[0], 1'b1);
    step();
    chk_idle("rel_idle", 0);

    // 0xA5, DIV=3, no parity
    send("a5", 0, 8'hA5, 16'd3);
    check_frame("a5", 0, {10'b0101001011, 22'b0}, 10, 4);

    // Even then odd parity, DIV=1
    send("pe", 1, 8'hA5, 16'd1);
    check_frame("pe", 1, {11'b01010010101, 21'b0}, 11, 2);
    send("po", 2, 8'hA5, 16'd1);
    check_frame("po", 2, {11'b01010010111, 21'b0}, 11, 2);

    // Two stop bits, DIV=0
    send("s2", 3, 8'h00, 16'd0);
    check_frame("s2", 3, {11'b00000000011, 21'b0}, 11, 1);

    // Back-to-back with TVALID held; TDATA changes during frame 1
    tdata     = 8'h01;
    div       = 16'd0;
    tvalid[0] = 1'b1;
    step();
    seq = {21'b010000000110000000011, 11'b0};
    for (int i = 0; i < 21; i++) begin
      if (i == 1) tdata = 8'h80;
      if (i == 11) tvalid[0] = 1'b0;
      chk($sformatf("b2b_so[%0d]", i), so[0], seq[i]);
      chk($sformatf("b2b_busy[%0d]", i), busy[0], (i != 10));
      chk($sformatf("b2b_tready[%0d]", i), tready[0], (i == 10));
      step();
    end
    chk_idle("b2b_end", 0);

    // DIV changed mid-frame only affects the next frame
    send("dv", 0, 8'h0F, 16'd3);
    seq = {10'b0111100001, 22'b0};
    for (int i = 0; i < 40; i++) begin
      if (i == 5) div = 16'd0;
      chk($sformatf("dv_so[%0d]", i), so[0], seq[i / 4]);
      chk($sformatf("dv_busy[%0d]", i), busy[0], 1'b1);
      step();
    end
    chk_idle("dv_end", 0);
    send("dv2", 0, 8'h33, 16'd0);
    check_frame("dv2", 0, {10'b0110011001, 22'b0}, 10, 1);

    // Reset during DATA of 0xFF
    send("rf", 0, 8'hFF, 16'd1);
    step();
    step();
    step();
    step();
    chk("rf_busy_pre", busy[0], 1'b1);
    rstn = 1'b0;
    #1;
    chk("rf_so", so[0], 1'b1);
    chk("rf_busy", busy[0], 1'b0);
    chk("rf_tready", tready[0], 1'b0);
    step();
    step();
    rstn = 1'b1;
    #1;
    chk("rf_rel_tready", tready[0], 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      chk_idle($sformatf("rf_quiet%0d", i), 0);
      step();
    end
    send("rf2", 0, 8'h5A, 16'd0);
    check_frame("rf2", 0, {10'b0010110101, 22'b0}, 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
